// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared types and helpers for the program loader
package loader_pkg;

    typedef enum logic [2:0] {
        LEN_LO = 3'd0,
        LEN_HI = 3'd1,
        DATA   = 3'd2,
        WRITE  = 3'd3,
        DONE   = 3'd4,
        ERR    = 3'd5
    } state_t;

    // Bytes per instruction word.
    function automatic int bpi(input int instr_w);
        return instr_w / 8;
    endfunction

endpackage

// File: rtl/prog_loader_if.sv
// rtl/prog_loader_if.sv - byte-stream input and imem write port of the loader
interface prog_loader_if #(
    parameter int INSTR_W = 16,
    parameter int ADDR_W  = 8
);
    logic [7:0]         rx_data;
    logic               rx_valid;
    logic               rx_ready;
    logic               imem_we;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_wdata;

    // Source side: drives the byte stream, observes the memory writes.
    modport master (
        output rx_data, rx_valid,
        input  rx_ready, imem_we, imem_addr, imem_wdata
    );

    // Loader side.
    modport slave (
        input  rx_data, rx_valid,
        output rx_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/word_packer.sv
// rtl/word_packer.sv - assembles little-endian instruction words from bytes
module word_packer
    import loader_pkg::*;
#(
    parameter int INSTR_W = 16
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [7:0]         i_byte,
    input  logic               i_strobe,
    input  logic               i_clear,
    output logic [INSTR_W-1:0] o_word,
    output logic               o_word_full
);
    localparam int BPI = bpi(INSTR_W);
    localparam int CW  = (BPI > 1) ? $clog2(BPI) : 1;

    logic [CW-1:0]      r_cnt;
    logic [INSTR_W-1:0] r_word;
    logic [INSTR_W-1:0] w_merged;

    // The word including the byte being strobed now, so the FSM can capture
    // a complete word on the same edge that accepts its last byte.
    always_comb begin
        w_merged = r_word;
        for (int b = 0; b < BPI; b++) begin
            if (r_cnt == CW'(b)) begin
                w_merged[b*8 +: 8] = i_byte;
            end
        end
    end

    assign o_word      = w_merged;
    assign o_word_full = i_strobe && (r_cnt == CW'(BPI - 1));

    // Byte counter and shift-in register; counter wraps when a word completes.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_cnt <= '0;
            if (i_reset) begin
                r_word <= '0;
            end
        end else if (i_strobe) begin
            r_word <= w_merged;
            r_cnt  <= o_word_full ? '0 : r_cnt + CW'(1);
        end
    end
endmodule

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - loads a byte-stream program image into instruction memory
module prog_loader
    import loader_pkg::*;
#(
    parameter int INSTR_W = 16,
    parameter int ADDR_W  = 8
) (
    input  logic            i_clk,
    input  logic            i_reset,
    prog_loader_if.slave    bus,
    output logic            o_core_hold,
    output logic            o_load_done,
    output logic            o_load_err,
    output logic [ADDR_W:0] o_instr_count
);
    localparam logic [16:0] CAP = 17'(1) << ADDR_W;

    state_t             r_state;
    logic               r_rx_ready;
    logic               r_imem_we;
    logic [ADDR_W-1:0]  r_imem_addr;
    logic [INSTR_W-1:0] r_imem_wdata;
    logic               r_core_hold;
    logic               r_load_done;
    logic               r_load_err;
    logic [ADDR_W:0]    r_instr_count;
    logic [7:0]         r_len_lo;
    logic [ADDR_W:0]    r_idx;

    logic               w_xfer;
    logic [16:0]        w_len;
    logic [ADDR_W:0]    w_idx_next;
    logic [INSTR_W-1:0] w_word;
    logic               w_word_full;

    assign w_xfer     = bus.rx_valid && r_rx_ready;
    assign w_len      = {1'b0, bus.rx_data, r_len_lo};
    assign w_idx_next = r_idx + {{ADDR_W{1'b0}}, 1'b1};

    word_packer #(.INSTR_W(INSTR_W)) u_packer (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_byte      (bus.rx_data),
        .i_strobe    (w_xfer && (r_state == DATA)),
        .i_clear     (r_state != DATA),
        .o_word      (w_word),
        .o_word_full (w_word_full)
    );

    // Loader FSM; every output is registered on the transition that defines it.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= LEN_LO;
            r_rx_ready    <= 1'b0;
            r_imem_we     <= 1'b0;
            r_imem_addr   <= '0;
            r_imem_wdata  <= '0;
            r_core_hold   <= 1'b1;
            r_load_done   <= 1'b0;
            r_load_err    <= 1'b0;
            r_instr_count <= '0;
            r_len_lo      <= '0;
            r_idx         <= '0;
        end else begin
            r_imem_we <= 1'b0;
            case (r_state)
                LEN_LO: begin
                    r_rx_ready <= 1'b1;
                    if (w_xfer) begin
                        r_len_lo <= bus.rx_data;
                        r_state  <= LEN_HI;
                    end
                end
                LEN_HI: begin
                    if (w_xfer) begin
                        r_instr_count <= w_len[ADDR_W:0];
                        if (w_len == 17'd0) begin
                            r_state     <= DONE;
                            r_rx_ready  <= 1'b0;
                            r_core_hold <= 1'b0;
                            r_load_done <= 1'b1;
                        end else if (w_len > CAP) begin
                            r_state    <= ERR;
                            r_rx_ready <= 1'b0;
                            r_load_err <= 1'b1;
                        end else begin
                            r_state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (w_xfer && w_word_full) begin
                        r_state      <= WRITE;
                        r_rx_ready   <= 1'b0;
                        r_imem_we    <= 1'b1;
                        r_imem_addr  <= r_idx[ADDR_W-1:0];
                        r_imem_wdata <= w_word;
                    end
                end
                WRITE: begin
                    r_idx <= w_idx_next;
                    if (w_idx_next < r_instr_count) begin
                        r_state    <= DATA;
                        r_rx_ready <= 1'b1;
                    end else begin
                        r_state     <= DONE;
                        r_core_hold <= 1'b0;
                        r_load_done <= 1'b1;
                    end
                end
                DONE, ERR: begin
                    r_rx_ready <= 1'b0;
                end
                default: begin
                    r_state    <= LEN_LO;
                    r_rx_ready <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rx_ready   = r_rx_ready;
    assign bus.imem_we    = r_imem_we;
    assign bus.imem_addr  = r_imem_addr;
    assign bus.imem_wdata = r_imem_wdata;
    assign o_core_hold    = r_core_hold;
    assign o_load_done    = r_load_done;
    assign o_load_err     = r_load_err;
    assign o_instr_count  = r_instr_count;
endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - directed self-checking bench for prog_loader
module tb_prog_loader;
    localparam int INSTR_W = 16;
    localparam int ADDR_W  = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic            core_hold;
    logic            load_done;
    logic            load_err;
    logic [ADDR_W:0] instr_count;

    prog_loader_if #(.INSTR_W(INSTR_W), .ADDR_W(ADDR_W)) bus ();

    prog_loader #(.INSTR_W(INSTR_W), .ADDR_W(ADDR_W)) dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .bus           (bus),
        .o_core_hold   (core_hold),
        .o_load_done   (load_done),
        .o_load_err    (load_err),
        .o_instr_count (instr_count)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    logic [ADDR_W-1:0]  wa[$];
    logic [INSTR_W-1:0] wd[$];

    always @(negedge clk) begin
        if (bus.imem_we) begin
            wa.push_back(bus.imem_addr);
            wd.push_back(bus.imem_wdata);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        while (!bus.rx_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!bus.rx_ready) check("rx_accept_timeout", 32'(bus.rx_ready), 32'd1);
        else @(posedge clk);
        @(negedge clk);
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'hEE;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_reset_vals(input string pfx);
        check({pfx, "_rx_ready"},   32'(bus.rx_ready),   32'd0);
        check({pfx, "_imem_we"},    32'(bus.imem_we),    32'd0);
        check({pfx, "_imem_addr"},  32'(bus.imem_addr),  32'd0);
        check({pfx, "_imem_wdata"}, 32'(bus.imem_wdata), 32'd0);
        check({pfx, "_core_hold"},  32'(core_hold),      32'd1);
        check({pfx, "_load_done"},  32'(load_done),      32'd0);
        check({pfx, "_load_err"},   32'(load_err),       32'd0);
        check({pfx, "_instr_cnt"},  32'(instr_count),    32'd0);
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        idle(2);
        wa.delete();
        wd.delete();
        reset = 1'b0;
    endtask

    task automatic send_nominal(input int max_gap);
        logic [7:0] nom [8];
        nom = '{8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        for (int i = 0; i < 8; i++) begin
            if (max_gap > 0) begin
                bus.rx_data = 8'hEE;
                idle($urandom_range(0, max_gap));
            end
            send_byte(nom[i]);
        end
    endtask

    task automatic check_nominal(input string pfx);
        check({pfx, "_nwrites"}, 32'(wa.size()), 32'd3);
        if (wa.size() == 3) begin
            check({pfx, "_a0"}, 32'(wa[0]), 32'h0);
            check({pfx, "_d0"}, 32'(wd[0]), 32'h2211);
            check({pfx, "_a1"}, 32'(wa[1]), 32'h1);
            check({pfx, "_d1"}, 32'(wd[1]), 32'h4433);
            check({pfx, "_a2"}, 32'(wa[2]), 32'h2);
            check({pfx, "_d2"}, 32'(wd[2]), 32'h6655);
        end
        check({pfx, "_done"},  32'(load_done),   32'd1);
        check({pfx, "_hold"},  32'(core_hold),   32'd0);
        check({pfx, "_err"},   32'(load_err),    32'd0);
        check({pfx, "_count"}, 32'(instr_count), 32'd3);
    endtask

    task automatic offer_dead(input string tag, input logic [7:0] b);
        int seen = 0;
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.rx_ready) seen++;
        end
        bus.rx_valid = 1'b0;
        check(tag, 32'(seen), 32'd0);
    endtask

    initial begin
        int w;
        int seq_bad;
        int zero_hits;
        int nw;

        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        reset        = 1'b1;
        idle(2);
        check_reset_vals("rst");
        wa.delete();
        wd.delete();
        reset = 1'b0;

        // Nominal image, back-to-back bytes; bytes queued during WRITE must wait.
        idle(1);
        send_nominal(0);
        check("nom_we_latency",   32'(bus.imem_we),  32'd1);
        check("nom_ready_in_wr",  32'(bus.rx_ready), 32'd0);
        idle(3);
        check_nominal("nom");
        nw = wa.size();
        offer_dead("nom_after_done_ready", 8'h77);
        idle(2);
        check("nom_after_done_writes", 32'(wa.size()), 32'(nw));

        // Empty image.
        do_reset();
        send_byte(8'h00);
        send_byte(8'h00);
        w = 0;
        while (core_hold && w < 2) begin
            @(negedge clk);
            w++;
        end
        check("empty_hold",  32'(core_hold),   32'd0);
        check("empty_done",  32'(load_done),   32'd1);
        check("empty_count", 32'(instr_count), 32'd0);
        idle(3);
        check("empty_nwrites", 32'(wa.size()), 32'd0);

        // Header larger than capacity.
        do_reset();
        send_byte(8'h01);
        send_byte(8'h01);
        idle(2);
        check("ovf_err",   32'(load_err),    32'd1);
        check("ovf_hold",  32'(core_hold),   32'd1);
        check("ovf_done",  32'(load_done),   32'd0);
        check("ovf_count", 32'(instr_count), 32'd257);
        offer_dead("ovf_ready", 8'h5A);
        idle(2);
        check("ovf_nwrites", 32'(wa.size()), 32'd0);

        // Full capacity: word i = {~i, i}.
        do_reset();
        send_byte(8'h00);
        send_byte(8'h01);
        for (int i = 0; i < 256; i++) begin
            send_byte(8'(i));
            send_byte(8'(~i));
        end
        idle(3);
        check("full_nwrites", 32'(wa.size()), 32'd256);
        seq_bad   = 0;
        zero_hits = 0;
        for (int i = 0; i < wa.size(); i++) begin
            if (wa[i] != 8'(i)) seq_bad++;
            if (wa[i] == 8'h00) zero_hits++;
        end
        check("full_seq_addr",  32'(seq_bad),   32'd0);
        check("full_addr0_hit", 32'(zero_hits), 32'd1);
        if (wa.size() == 256) begin
            check("full_last_addr", 32'(wa[255]), 32'hFF);
            check("full_d255",      32'(wd[255]), 32'h00FF);
            check("full_d128",      32'(wd[128]), 32'h7F80);
        end
        check("full_done",  32'(load_done),   32'd1);
        check("full_hold",  32'(core_hold),   32'd0);
        check("full_count", 32'(instr_count), 32'd256);

        // Nominal image with random idle gaps.
        do_reset();
        send_nominal(3);
        idle(3);
        check_nominal("gap");

        // Reset in the middle of a load, then a clean reload.
        do_reset();
        send_byte(8'h03);
        send_byte(8'h00);
        send_byte(8'h11);
        send_byte(8'h22);
        idle(1);
        check("mid_word1_written", 32'(wa.size()), 32'd1);
        send_byte(8'h33);
        reset = 1'b1;
        idle(1);
        check_reset_vals("mid");
        idle(1);
        wa.delete();
        wd.delete();
        reset = 1'b0;
        idle(1);
        check("mid_hold_after_rst", 32'(core_hold), 32'd1);
        send_nominal(0);
        idle(3);
        check_nominal("reload");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
